fft_twiddle_mul: RTL
====================

Name: fft_twiddle_mul

Overview:
- Consumer end of the twiddle-factor interface: accepts one complex sample per cycle and multiplies it by the W_real/W_imag pair that a W_control-style generator drives on the same cycle.
- Sits between a butterfly stage's output and the next stage's input.
- Applies the convention that W = (0,0) is the generator's "no rotation" slot, so those samples pass through unchanged.
- Also tracks the position of each sample within the 33-cycle generator period.

Parameters:
- DW, 16, data width of sample real/imag, signed two's complement
- WW, 16, twiddle width, signed two's complement
- WFRAC, 14, twiddle fraction bits; 1.0 = 2^WFRAC = 16384
- PERIOD, 33, generator period in cycles (count 0..PERIOD-1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  sample qualifier
- x_real  in  DW  input sample real part
- x_imag  in  DW  input sample imag part
- W_real  in  WW  twiddle real part, sampled together with x
- W_imag  in  WW  twiddle imag part, sampled together with x
- out_valid  out  1  result qualifier
- y_real  out  DW  rotated real part
- y_imag  out  DW  rotated imag part
- out_index  out  6  period slot (0..PERIOD-1) of the emitted sample

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous and active-low.
- Reset values: out_valid=0, y_real=0, y_imag=0, out_index=0, slot counter=0, all pipeline valid bits=0.
- Slot counter (6 bit):
  - Increments on every cycle with in_valid=1.
  - Wraps from PERIOD-1 to 0.
  - Holds while in_valid=0.
  - The slot value is captured with the sample.
- Pipeline: 3 stages, fixed latency 3 cycles from the in_valid edge to the out_valid edge. No backpressure.
  - S1: register x, W, slot, and the flag bypass = (W_real==0 && W_imag==0).
  - S2: register the four signed products xr*Wr, xi*Wi, xr*Wi, xi*Wr, each DW+WW bits.
  - S3: compute re = xr*Wr - xi*Wi and im = xr*Wi + xi*Wr at DW+WW+1 bits, then shift right arithmetic by WFRAC, saturate to DW bits, and register.
- Saturation: clamp to [-2^(DW-1), 2^(DW-1)-1]; no wrap-around permitted.
- Bypass: when the bypass flag is set, y = x delayed 3 cycles, bit-exact; no multiply and no rounding.
- Invalid cycles: stage registers still advance, but valid bits clear. y holds its last valid value while out_valid=0.
- Gapped input: valid bits are carried per stage, so in_valid gaps propagate exactly with identical latency.
- Reset mid-stream: all in-flight samples are discarded. out_valid drops immediately (async). The slot counter restarts at 0 on the first post-reset valid sample.
- Multiplication is fully signed. -32768 * -16384 is a legal input and must saturate correctly after the shift.

Optional Feature:
- Macro: TWIDDLE_ROUND_EN.
- Defined: round half up before the shift, by adding 2^(WFRAC-1) to re and im ahead of the arithmetic shift right. Saturation is applied after rounding.
- Undefined: plain truncation (floor) via the arithmetic shift.
- Bypass path unaffected in both cases. Latency stays 3 in both builds.

Test Plan:
- Identity: x=(1234,-567), W=(16384,0), in_valid=1 -> after 3 cycles y=(1234,-567), out_valid=1, out_index=0.
- Rotate by j: x=(1000,200), W=(0,16384) -> y=(-200,1000).
- Saturation: x=(-32768,-32768), W=(16384,-16384) -> y=(-32768,0); no wrap.
- Rounding: x=(1,0), W=(8192,0) -> y_real=1 with TWIDDLE_ROUND_EN, 0 without. x=(-1,0), same W -> y_real=0 with the macro, -1 without.
- Bypass and slot wrap:
  - Stream 34 valid samples with W=(0,0) and x=(n,-n) for n=0..33.
  - Expect y=(n,-n) exactly.
  - out_index runs 0..32 then returns to 0.
  - Insert a 2-cycle in_valid gap; the gap appears at the output 3 cycles later and out_index holds across it.
- Reset mid-stream: assert rst_n=0 with 3 samples in flight -> out_valid=0 immediately, y=0. After release, the first valid sample emerges 3 cycles later with out_index=0.

Source files
------------

// File: rtl/fft_twiddle_mul.sv
// Complex sample x twiddle multiplier, 3-stage pipeline, with generator period slot tracking.
// Optional macro TWIDDLE_ROUND_EN selects round-half-up before the shift; default build truncates.
module fft_twiddle_mul #(
    parameter int DW     = 16,
    parameter int WW     = 16,
    parameter int WFRAC  = 14,
    parameter int PERIOD = 33
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] x_real,
    input  logic signed [DW-1:0] x_imag,
    input  logic signed [WW-1:0] W_real,
    input  logic signed [WW-1:0] W_imag,
    output logic                 out_valid,
    output logic signed [DW-1:0] y_real,
    output logic signed [DW-1:0] y_imag,
    output logic [5:0]           out_index
);

    localparam int PW = DW + WW;
    localparam int SW = PW + 1;
    localparam logic [5:0] LAST_SLOT = 6'(PERIOD - 1);

    logic [5:0]           r_slot;

    logic                 r_s1_vld;
    logic                 r_s1_byp;
    logic signed [DW-1:0] r_s1_xr;
    logic signed [DW-1:0] r_s1_xi;
    logic signed [WW-1:0] r_s1_wr;
    logic signed [WW-1:0] r_s1_wi;
    logic [5:0]           r_s1_slot;

    logic                 r_s2_vld;
    logic                 r_s2_byp;
    logic signed [DW-1:0] r_s2_xr;
    logic signed [DW-1:0] r_s2_xi;
    logic [5:0]           r_s2_slot;
    logic signed [PW-1:0] r_s2_prr;
    logic signed [PW-1:0] r_s2_pii;
    logic signed [PW-1:0] r_s2_pri;
    logic signed [PW-1:0] r_s2_pir;

    logic                 r_s3_vld;
    logic signed [DW-1:0] r_s3_yr;
    logic signed [DW-1:0] r_s3_yi;
    logic [5:0]           r_s3_idx;

    logic signed [SW-1:0] w_rnd;
    logic signed [SW-1:0] w_re;
    logic signed [SW-1:0] w_im;
    logic signed [SW-1:0] w_re_sh;
    logic signed [SW-1:0] w_im_sh;

`ifdef TWIDDLE_ROUND_EN
    assign w_rnd = {{(SW-WFRAC){1'b0}}, 1'b1, {(WFRAC-1){1'b0}}};
`else
    assign w_rnd = '0;
`endif

    // One extra bit holds the worst case (-2^(DW-1))*(-2^(WW-1)) summed twice.
    assign w_re    = SW'(r_s2_prr) - SW'(r_s2_pii) + w_rnd;
    assign w_im    = SW'(r_s2_pri) + SW'(r_s2_pir) + w_rnd;
    assign w_re_sh = w_re >>> WFRAC;
    assign w_im_sh = w_im >>> WFRAC;

    function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] v);
        if ((&v[SW-1:DW-1]) || !(|v[SW-1:DW-1]))
            return v[DW-1:0];
        else if (v[SW-1])
            return {1'b1, {(DW-1){1'b0}}};
        else
            return {1'b0, {(DW-1){1'b1}}};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot    <= '0;
            r_s1_vld  <= 1'b0;
            r_s1_byp  <= 1'b0;
            r_s1_xr   <= '0;
            r_s1_xi   <= '0;
            r_s1_wr   <= '0;
            r_s1_wi   <= '0;
            r_s1_slot <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_byp  <= 1'b0;
            r_s2_xr   <= '0;
            r_s2_xi   <= '0;
            r_s2_slot <= '0;
            r_s2_prr  <= '0;
            r_s2_pii  <= '0;
            r_s2_pri  <= '0;
            r_s2_pir  <= '0;
            r_s3_vld  <= 1'b0;
            r_s3_yr   <= '0;
            r_s3_yi   <= '0;
            r_s3_idx  <= '0;
        end else begin
            if (in_valid)
                r_slot <= (r_slot == LAST_SLOT) ? '0 : r_slot + 6'd1;

            r_s1_vld  <= in_valid;
            r_s1_byp  <= (W_real == '0) && (W_imag == '0);
            r_s1_xr   <= x_real;
            r_s1_xi   <= x_imag;
            r_s1_wr   <= W_real;
            r_s1_wi   <= W_imag;
            r_s1_slot <= r_slot;

            r_s2_vld  <= r_s1_vld;
            r_s2_byp  <= r_s1_byp;
            r_s2_xr   <= r_s1_xr;
            r_s2_xi   <= r_s1_xi;
            r_s2_slot <= r_s1_slot;
            r_s2_prr  <= PW'(r_s1_xr) * PW'(r_s1_wr);
            r_s2_pii  <= PW'(r_s1_xi) * PW'(r_s1_wi);
            r_s2_pri  <= PW'(r_s1_xr) * PW'(r_s1_wi);
            r_s2_pir  <= PW'(r_s1_xi) * PW'(r_s1_wr);

            // Output data only moves on valid samples so it holds through gaps.
            r_s3_vld <= r_s2_vld;
            if (r_s2_vld) begin
                r_s3_yr  <= r_s2_byp ? r_s2_xr : sat(w_re_sh);
                r_s3_yi  <= r_s2_byp ? r_s2_xi : sat(w_im_sh);
                r_s3_idx <= r_s2_slot;
            end
        end
    end

    assign out_valid = r_s3_vld;
    assign y_real    = r_s3_yr;
    assign y_imag    = r_s3_yi;
    assign out_index = r_s3_idx;

endmodule
